// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU responder: opcode encodings, FSM states and
// the default multiplier latency.
package tinyalu_pkg;

  localparam int MUL_LATENCY_DEFAULT = 3;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    MUL      = 2'b10,
    WAIT_LOW = 2'b11
  } state_t;

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Registered unsigned DATA_W x DATA_W multiplier with MUL_LATENCY-1 stages
// after the operand latch; out_valid marks the product leaving the last stage.
module tinyalu_mul_pipe #(
  parameter int DATA_W      = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int STAGES = MUL_LATENCY - 1;

  logic [STAGES-1:0]   vld_d, vld_q;
  logic [2*DATA_W-1:0] prod_d [STAGES];
  logic [2*DATA_W-1:0] prod_q [STAGES];

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_valid;
    prod_d[0] = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k]  = vld_q[k-1];
      prod_d[k] = prod_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign product   = prod_q[STAGES-1];

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU responder: accepts a start/done command, runs add/and/xor in one
// cycle or mul through the pipelined multiplier, and pulses done once.
//
// state    | meaning
// IDLE     | waiting for start; latches A, B, op when it is seen
// EXEC     | single-cycle op; result and done registered on the next edge
// MUL      | waiting for the multiplier pipeline to deliver the product
// WAIT_LOW | command finished or dropped; wait for start to be released
module tinyalu_core
  import tinyalu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [2:0]          op,
  input  logic                start,
  output logic                done,
  output logic [2*DATA_W-1:0] result
);

  state_t              state_d, state_q;
  operation_t          op_d, op_q, op_in;
  logic [DATA_W-1:0]   a_d, a_q, b_d, b_q;
  logic [2*DATA_W-1:0] result_d, result_q;
  logic                done_d, done_q;
  logic                mul_go_d, mul_go_q;
  logic                mul_valid;
  logic [2*DATA_W-1:0] mul_product;

  function automatic logic [2*DATA_W-1:0] alu_eval(
    input operation_t        o,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y
  );
    logic [2*DATA_W-1:0] xe, ye;
    xe = {{DATA_W{1'b0}}, x};
    ye = {{DATA_W{1'b0}}, y};
    case (o)
      add_op:  alu_eval = xe + ye;
      and_op:  alu_eval = xe & ye;
      xor_op:  alu_eval = xe ^ ye;
      default: alu_eval = '0;
    endcase
  endfunction

  assign op_in = operation_t'(op);

  // Operands come only from the latched copy, so the bus may change freely
  // once the command has been accepted.
  tinyalu_mul_pipe #(
    .DATA_W      (DATA_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (mul_go_q),
    .a         (a_q),
    .b         (b_q),
    .out_valid (mul_valid),
    .product   (mul_product)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    mul_go_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d  = A;
          b_d  = B;
          op_d = op_in;
          case (op_in)
            add_op, and_op, xor_op: state_d = EXEC;
            mul_op: begin
              state_d  = MUL;
              mul_go_d = 1'b1;
            end
            default: state_d = WAIT_LOW;
          endcase
        end
      end
      EXEC: begin
        result_d = alu_eval(op_q, a_q, b_q);
        done_d   = 1'b1;
        state_d  = WAIT_LOW;
      end
      MUL: begin
        if (mul_valid) begin
          result_d = mul_product;
          done_d   = 1'b1;
          state_d  = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= no_op;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      mul_go_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
      mul_go_q <= mul_go_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Self-checking bench for tinyalu_core: a MUL_LATENCY=3 and a MUL_LATENCY=5
// instance share stimulus; expected results are queued per instance on drive.
module tb_tinyalu_core;

  logic        clk;
  logic        reset_n;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        start;
  logic        done3, done5;
  logic [15:0] result3, result5;

  logic [15:0] sb3[$];
  logic [15:0] sb5[$];
  int          n_vec;
  int          n_err;

  tinyalu_core #(.DATA_W(8), .MUL_LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .start(start),
    .done(done3), .result(result3)
  );

  tinyalu_core #(.DATA_W(8), .MUL_LATENCY(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .start(start),
    .done(done5), .result(result5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] o);
    case (o)
      3'd1:    model = {8'h00, a} + {8'h00, b};
      3'd2:    model = {8'h00, a & b};
      3'd3:    model = {8'h00, a ^ b};
      3'd4:    model = 16'(a) * 16'(b);
      default: model = 16'h0000;
    endcase
  endfunction

  // Issues one command, watches both instances for 12 cycles, then releases
  // start so the next call can raise it right after it is sampled low.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input logic [15:0] exp_res, input bit poke_a);
    bit          does_done;
    int          lat3, lat5, n3, n5, dbl3, dbl5, unexp;
    logic        p3, p5;
    logic [15:0] r3_before, r5_before;
    does_done = (o >= 3'd1) && (o <= 3'd4);
    @(negedge clk);
    A = a; B = b; op = o; start = 1'b1;
    r3_before = result3;
    r5_before = result5;
    if (does_done) begin
      sb3.push_back(exp_res);
      sb5.push_back(exp_res);
    end
    @(posedge clk);
    lat3 = -1; lat5 = -1; n3 = 0; n5 = 0; dbl3 = 0; dbl5 = 0; unexp = 0;
    p3 = 1'b0; p5 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0 && poke_a) A = 8'h00;
      if (j == 0 && !does_done) start = 1'b0;
      if (done3) begin
        n3++;
        if (lat3 < 0) lat3 = j;
        if (p3) dbl3++;
        if (sb3.size() == 0) unexp++;
        else chk("result3", 32'(result3), 32'(sb3.pop_front()));
      end
      if (done5) begin
        n5++;
        if (lat5 < 0) lat5 = j;
        if (p5) dbl5++;
        if (sb5.size() == 0) unexp++;
        else chk("result5", 32'(result5), 32'(sb5.pop_front()));
      end
      p3 = done3;
      p5 = done5;
    end
    chk("unexpected_done", unexp, 0);
    if (does_done) begin
      chk("latency3", lat3, (o == 3'd4) ? 3 : 1);
      chk("latency5", lat5, (o == 3'd4) ? 5 : 1);
      chk("done_count3", n3, 1);
      chk("done_count5", n5, 1);
      chk("done_back2back", dbl3 + dbl5, 0);
    end else begin
      chk("noop_done3", n3, 0);
      chk("noop_done5", n5, 0);
      chk("noop_result3", 32'(result3), 32'(r3_before));
      chk("noop_result5", 32'(result5), 32'(r5_before));
    end
    start = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nd;
    logic [7:0]  ra, rb;
    logic [2:0]  ro;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; start = 1'b0; A = '0; B = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done3", done3, 0);
    chk("rst_result3", 32'(result3), 0);
    chk("rst_done5", done5, 0);
    chk("rst_result5", 32'(result5), 0);
    reset_n = 1'b1;

    run_cmd(8'hFF, 8'h01, 3'b001, 16'h0100, 1'b0);
    run_cmd(8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0);
    run_cmd(8'hF0, 8'h3C, 3'b011, 16'h00CC, 1'b0);
    run_cmd(8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b1);
    run_cmd(8'h12, 8'h34, 3'b000, 16'h0000, 1'b0);
    run_cmd(8'h56, 8'h78, 3'b110, 16'h0000, 1'b0);
    run_cmd(8'h02, 8'h03, 3'b001, 16'h0005, 1'b0);

    // Reset lands one edge into a multiply; the command must vanish.
    @(negedge clk);
    A = 8'h10; B = 8'h10; op = 3'b100; start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_done3", done3, 0);
    chk("arst_result3", 32'(result3), 0);
    chk("arst_done5", done5, 0);
    chk("arst_result5", 32'(result5), 0);
    nd = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (done3 || done5) nd++;
    end
    chk("arst_no_done", nd, 0);
    start = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    nd = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (done3 || done5) nd++;
    end
    chk("post_rst_no_done", nd, 0);

    run_cmd(8'h02, 8'h03, 3'b100, 16'h0006, 1'b0);
    run_cmd(8'h80, 8'h02, 3'b100, 16'h0100, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 3'($urandom_range(1, 4));
      run_cmd(ra, rb, ro, model(ra, rb, ro), 1'b0);
    end

    chk("sb3_left", sb3.size(), 0);
    chk("sb5_left", sb5.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tinyalu_core.md
Name: tinyalu_core

Overview:
- Synthesisable responder end of the TinyALU start/done command protocol. It is the DUT side that the team's bus-functional model and monitors drive and observe.
- Samples A, B and op when start is raised, executes the operation and returns a 16-bit result with a one-cycle done pulse.
- Single-cycle path for add/and/xor; multi-cycle pipelined path for mul.

Parameters:
- MUL_LATENCY, 3: edges from command capture to done for mul_op. Legal range 2..8.
- DATA_W, 8: operand width. result width is 2*DATA_W.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- A, input, DATA_W: operand A.
- B, input, DATA_W: operand B.
- op, input, 3: opcode. 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 101..111 unsupported.
- start, input, 1: command request, held high by the initiator until done is seen.
- done, output, 1: one-cycle completion pulse.
- result, output, 2*DATA_W: operation result, valid while done=1 and held afterwards.

Behaviour:
- Clock is clk; reset is reset_n, asynchronous, active-low, with one clock domain.
- Reset values: done=0, result=0, state=IDLE, and the mul pipeline valid bits are cleared. Reset asserted mid-operation discards the pending command, and no done follows.
- State machine states: IDLE, EXEC, MUL, WAIT_LOW.
- IDLE, start=1 on edge E: latch A, B and op.
  - add/and/xor: go to EXEC.
  - mul: go to MUL and launch the multiplier pipeline.
  - no_op or 101..111: go to WAIT_LOW; no done, and result is unchanged.
- EXEC: at edge E+1, register result, set done=1, go to WAIT_LOW.
- MUL: at edge E+MUL_LATENCY, register the product, set done=1, go to WAIT_LOW.
- WAIT_LOW:
  - done clears on the next edge.
  - Stay here while start=1; go to IDLE on the first edge that samples start=0.
  - A command is therefore never re-executed while start is held.
- Back-to-back throughput: start may rise again on the edge after it is sampled low.
- Operands and op are taken only from the latched copy. Changes to A, B, op or start during EXEC or MUL are ignored, and the operation completes.
- Arithmetic, all unsigned and zero-extended to 2*DATA_W:
  - add: A+B, with carry in bit DATA_W.
  - and: A&B.
  - xor: A^B.
  - mul: A*B, full-width with no truncation.
- result keeps its last value until the next done or reset.
- done is never high for two consecutive cycles.

Decomposition:
- tinyalu_pkg holds:
  - operation_t enum (no_op, add_op, and_op, xor_op, mul_op, rst_op) with the encodings above;
  - the state_t enum;
  - localparam MUL_LATENCY_DEFAULT=3.
- Sub-module tinyalu_mul_pipe:
  - Registered DATA_W x DATA_W unsigned multiplier, MUL_LATENCY-1 stages after the operand latch.
  - Ports: clk, reset_n, in_valid, a, b, out_valid, product.
  - The top FSM raises done on out_valid.

Test Plan:
- Add after reset: A=8'hFF, B=8'h01, op=add, start held → done at E+1 with result=16'h0100; done is a single cycle; no second done while start stays high.
- Logic ops back-to-back: A=8'hF0, B=8'h3C, and → result=16'h0030; then xor → result=16'h00CC. Each second command is accepted only after start was sampled low for one edge.
- Multiply: A=8'hFF, B=8'hFF, op=mul → done exactly at E+3 with result=16'hFE01. Changing A to 8'h00 at E+1 does not alter the result.
- no_op and op=3'b110 with start high for one cycle → done never asserts and result keeps its previous value. A following add of 2+3 gives result=16'h0005.
- Drop reset_n at E+1 of a mul of 8'h10*8'h10:
  - done and result go to 0 immediately, asynchronously;
  - no done at E+3;
  - after release, a new mul of 8'h02*8'h03 gives result=16'h0006.
- MUL_LATENCY=5 build: 8'h80*8'h02 → done at E+5 with result=16'h0100.
